// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed 7-segment scan sequencer with double-buffered digit store
// Optional brightness dimming is enabled by defining SEG_DIM_EN.
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic       commit_busy,
  input  logic [7:0] digit_en,
`ifdef SEG_DIM_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] AN,
  output logic [3:0] code,
  output logic [2:0] scan_idx,
  output logic       frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic          commit_pending;
  logic [3:0]    shadow [8];
  logic [3:0]    active [8];

  logic          slot_end;
  logic          frame_end;
  logic          wr_fire;
  logic          lit;
  logic [7:0]    an_next;

  assign slot_end    = (slot_cnt == LAST);
  assign frame_end   = slot_end && (idx == 3'd7);
  assign wr_ready    = ~commit_pending;
  assign commit_busy = commit_pending;
  assign wr_fire     = wr_valid && wr_ready;
  assign scan_idx    = idx;

`ifdef SEG_DIM_EN
  localparam int STEP = (DIV - BLANK) / 8;

  logic [2:0]  bright_r;
  logic [31:0] show_ofs;
  logic [31:0] lit_lim;

  // Brightness is latched once per slot so a digit never changes duty mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_r <= 3'd0;
    end else if (slot_cnt == '0) begin
      bright_r <= bright;
    end
  end

  assign show_ofs = 32'(slot_cnt) - 32'(BLANK);
  assign lit_lim  = 32'(STEP) * (32'(bright_r) + 32'd1);
  assign lit      = (slot_cnt >= BLANK_C) && digit_en[idx] && (show_ofs < lit_lim);
`else
  assign lit      = (slot_cnt >= BLANK_C) && digit_en[idx];
`endif

  assign an_next = lit ? ~(8'b1 << idx) : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt       <= '0;
      idx            <= 3'd0;
      AN             <= 8'hFF;
      code           <= 4'd0;
      frame_done     <= 1'b0;
      commit_pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end

      AN         <= an_next;
      code       <= active[idx];
      frame_done <= frame_end;

      if (wr_fire) begin
        shadow[wr_addr] <= wr_data;
      end

      // Swap only at the frame boundary so a frame never mixes old and new digits.
      if (frame_end && commit_pending) begin
        for (int i = 0; i < 8; i++) begin
          active[i] <= shadow[i];
        end
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with DIV=8, BLANK=2
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       commit = 1'b0;
  logic       commit_busy;
  logic [7:0] digit_en = 8'hFF;
`ifdef SEG_DIM_EN
  logic [2:0] bright = 3'd7;
`endif
  logic [7:0] AN;
  logic [3:0] code;
  logic [2:0] scan_idx;
  logic       frame_done;

  seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .commit_busy(commit_busy),
    .digit_en   (digit_en),
`ifdef SEG_DIM_EN
    .bright     (bright),
`endif
    .AN         (AN),
    .code       (code),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle number since the last reset release; -1 while reset is held.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int cyc_now();
    return rst_n ? cyc : -1;
  endfunction

  typedef struct {
    int         c;
    logic [7:0] an;
    logic [3:0] cd;
    logic [2:0] si;
    logic       fd;
    logic       bz;
    logic       rd;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  task automatic push(input int c, input logic [7:0] an, input logic [3:0] cd,
                      input logic [2:0] si, input logic fd, input logic bz, input logic rd);
    exp_t e;
    e.c = c; e.an = an; e.cd = cd; e.si = si; e.fd = fd; e.bz = bz; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc_now() != n) begin
      @(negedge clk);
      g++;
      if (g > 5000) begin
        miss_cnt++;
        $display("FAIL wait_cyc: reached cycle %0d, required cycle %0d", cyc_now(), n);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   c;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      c = cyc_now();
      while (exp_q.size() > 0 && exp_q[0].c < c) begin
        e = exp_q.pop_front();
        vec_cnt++;
        miss_cnt++;
        $display("FAIL vec@%0d: not sampled, now at cycle %0d", e.c, c);
      end
      if (exp_q.size() > 0 && exp_q[0].c == c) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if ({AN, code, scan_idx, frame_done, commit_busy, wr_ready} !==
            {e.an, e.cd, e.si, e.fd, e.bz, e.rd}) begin
          miss_cnt++;
          $display("FAIL vec@%0d: got AN=%h code=%h idx=%0d fd=%b busy=%b rdy=%b, want AN=%h code=%h idx=%0d fd=%b busy=%b rdy=%b",
                   e.c, AN, code, scan_idx, frame_done, commit_busy, wr_ready,
                   e.an, e.cd, e.si, e.fd, e.bz, e.rd);
        end
      end
    end
  end

  initial begin : stimulus
    int g;
    // Reset state, then blanking and scan of frame 0
    push(-1,  8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(1,   8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(2,   8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(3,   8'hFE, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(7,   8'hFE, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(8,   8'hFE, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    push(9,   8'hFF, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    push(11,  8'hFD, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    // Write+commit at cycle 20; data stays hidden for the rest of frame 0
    push(21,  8'hFB, 4'h0, 3'd2, 1'b0, 1'b1, 1'b0);
    push(28,  8'hF7, 4'h0, 3'd3, 1'b0, 1'b1, 1'b0);
    push(40,  8'hEF, 4'h0, 3'd5, 1'b0, 1'b1, 1'b0);
    push(63,  8'h7F, 4'h0, 3'd7, 1'b0, 1'b1, 1'b0);
    push(64,  8'h7F, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    push(65,  8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(88,  8'hFB, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1);
    push(89,  8'hFF, 4'hA, 3'd3, 1'b0, 1'b0, 1'b1);
    push(92,  8'hF7, 4'hA, 3'd3, 1'b0, 1'b0, 1'b1);
    push(100, 8'hEF, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1);
    // Commit in the frame-end cycle waits a whole frame
    push(127, 8'h7F, 4'h0, 3'd7, 1'b0, 1'b0, 1'b1);
    push(128, 8'h7F, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    push(180, 8'hBF, 4'h0, 3'd6, 1'b0, 1'b1, 1'b0);
    push(192, 8'h7F, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    push(244, 8'hBF, 4'h9, 3'd6, 1'b0, 1'b0, 1'b1);
    // digit_en=7E from cycle 251
    push(251, 8'h7F, 4'h0, 3'd7, 1'b0, 1'b0, 1'b1);
    push(252, 8'hFF, 4'h0, 3'd7, 1'b0, 1'b0, 1'b1);
    push(256, 8'hFF, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    push(259, 8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(263, 8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(267, 8'hFD, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    push(283, 8'hF7, 4'hA, 3'd3, 1'b0, 1'b0, 1'b1);
    push(300, 8'hDF, 4'h0, 3'd5, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    wait_cyc(20);
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; commit = 1'b1;
    wait_cyc(21);
    wr_valid = 1'b0; commit = 1'b0;

    wait_cyc(40);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h5; commit = 1'b1;
    wait_cyc(41);
    wr_valid = 1'b0; commit = 1'b0;

    wait_cyc(127);
    wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 4'h9; commit = 1'b1;
    wait_cyc(128);
    wr_valid = 1'b0; commit = 1'b0;

    wait_cyc(251);
    digit_en = 8'h7E;

    // Asynchronous reset in slot 5; scan restarts and both buffers are clear
    wait_cyc(300);
    #2 push(-1, 8'hFF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    digit_en = 8'hFF;
    push(3,   8'hFE, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    push(28,  8'hF7, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1);
    push(31,  8'hF7, 4'h0, 3'd3, 1'b0, 1'b1, 1'b0);
    push(64,  8'h7F, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    push(92,  8'hF7, 4'h0, 3'd3, 1'b0, 1'b0, 1'b1);
    push(128, 8'h7F, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    wait_cyc(30);
    commit = 1'b1;
    wait_cyc(31);
    commit = 1'b0;

    wait_cyc(130);
    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    while (exp_q.size() > 0) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL vec@%0d: never sampled, required one sample", exp_q[0].c);
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
